// File: rtl/str_pkg.sv
// Shared definitions for the str_* stream blocks: address-width helper,
// default pointer type and the status bundle other stream blocks reuse.
package str_pkg;

    function automatic int str_aw(input int dn);
        return $clog2(dn);
    endfunction

    localparam int STR_DN_DEF = 16;
    localparam int STR_AW_DEF = str_aw(STR_DN_DEF);

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    typedef logic [STR_AW_DEF:0] str_ptr_t;

    typedef struct packed {
        logic [STR_AW_DEF:0] level;
        logic                afull;
    } str_status_t;

endpackage

// File: rtl/str_fifo_if.sv
// tvalid/tready/tvalue stream bundle; master drives the data, slave drives tready.
interface str_fifo_if #(
    parameter int VW = 32
);
    logic          tvalid;
    logic          tready;
    logic [VW-1:0] tvalue;

    modport master (output tvalid, output tvalue, input tready);
    modport slave  (input tvalid, input tvalue, output tready);
endinterface

// File: rtl/str_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read (LUTRAM).
module str_mem
    import str_pkg::*;
#(
    parameter int VW = 32,
    parameter int DN = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [str_aw(DN)-1:0] waddr,
    input  logic [VW-1:0]         wdata,
    input  logic [str_aw(DN)-1:0] raddr,
    output logic [VW-1:0]         rdata
);

    logic [VW-1:0] r_mem [DN];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/str_fifo.sv
// First-word-fall-through stream FIFO with registered handshakes, fill level,
// almost-full flag and synchronous flush.
module str_fifo
    import str_pkg::*;
#(
    parameter int VW = 32,
    parameter int DN = 16,
    parameter int AF = DN - 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    str_fifo_if.slave         sti,
    str_fifo_if.master        sto,
    output logic [str_aw(DN):0] level,
    output logic              afull
);

    localparam int          AW   = str_aw(DN);
    localparam logic [AW:0] AF_L = AF[AW:0];
    localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_afull;
    logic          r_sti_tready;
    logic          r_sto_tvalid;

    logic          w_push;
    logic          w_pop;
    logic [AW:0]   w_wr_next;
    logic [AW:0]   w_rd_next;
    logic [AW:0]   w_level_next;
    logic          w_full_next;
    logic          w_empty_next;
    logic [VW-1:0] w_rdata;

    assign w_push = sti.tvalid & r_sti_tready;
    assign w_pop  = r_sto_tvalid & sto.tready;

    always_comb begin
        w_wr_next    = r_wr_ptr;
        w_rd_next    = r_rd_ptr;
        w_level_next = r_level;
        if (flush) begin
            w_wr_next    = '0;
            w_rd_next    = '0;
            w_level_next = '0;
        end else begin
            if (w_push) w_wr_next = r_wr_ptr + ONE;
            if (w_pop)  w_rd_next = r_rd_ptr + ONE;
            case ({w_push, w_pop})
                2'b10:   w_level_next = r_level + ONE;
                2'b01:   w_level_next = r_level - ONE;
                default: w_level_next = r_level;
            endcase
        end
    end

    // Flags come from the next pointer state so they can be registered outputs.
    assign w_empty_next = (w_wr_next == w_rd_next);
    assign w_full_next  = (w_wr_next[AW-1:0] == w_rd_next[AW-1:0]) &&
                          (w_wr_next[AW] != w_rd_next[AW]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_afull      <= 1'b0;
            r_sti_tready <= 1'b1;
            r_sto_tvalid <= 1'b0;
        end else begin
            r_wr_ptr     <= w_wr_next;
            r_rd_ptr     <= w_rd_next;
            r_level      <= w_level_next;
            r_afull      <= (w_level_next >= AF_L);
            r_sti_tready <= ~w_full_next;
            r_sto_tvalid <= ~w_empty_next;
        end
    end

    str_mem #(
        .VW (VW),
        .DN (DN)
    ) u_mem (
        .clk   (clk),
        .we    (w_push & ~flush),
        .waddr (r_wr_ptr[AW-1:0]),
        .wdata (sti.tvalue),
        .raddr (r_rd_ptr[AW-1:0]),
        .rdata (w_rdata)
    );

    assign sti.tready = r_sti_tready;
    assign sto.tvalid = r_sto_tvalid;
    assign sto.tvalue = w_rdata;
    assign level      = r_level;
    assign afull      = r_afull;

endmodule
